// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one write port and one synchronous read port of a
//                single-clock Ram between the instruction-fetch requester (I)
//                and the load/store requester (D). D writes are always
//                accepted. Reads are issued at most one per cycle, with
//                round-robin on ties. Same-address I-read / D-write
//                collisions are resolved in favour of the write. Read data
//                returns with 1-cycle latency and is routed to its owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // instruction-fetch requester (read only)
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,

  // load/store requester (read or write)
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,

  // Ram ports
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // Which requester owns the read data arriving from the Ram this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Encoding of the round-robin history bit.
  localparam logic c_last_d = 1'b0;
  localparam logic c_last_i = 1'b1;

  owner_t                r_owner;
  logic                  r_last_rd;
  logic [DATA_WIDTH-1:0] r_i_hold;
  logic [DATA_WIDTH-1:0] r_d_hold;

  logic w_d_write;
  logic w_d_read;
  logic w_hazard;
  logic w_i_cand;
  logic w_grant_i;
  logic w_grant_d;

  // Request qualification, hazard detection and read-port arbitration.
  // Everything is gated by rst so no grant or Ram strobe leaks out while
  // the block is held in reset.
  always_comb begin
    w_d_write = rst & d_req & d_we;
    w_d_read  = rst & d_req & ~d_we;
    // An I read colliding with a D write to the same word waits one cycle
    // so it observes the freshly written data instead of the stale word.
    w_hazard  = w_d_write & i_req & (i_addr == d_addr);
    w_i_cand  = rst & i_req & ~w_hazard;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (w_i_cand && w_d_read) begin
      // Tie: alternate, favouring whoever did not win the last read.
      if (r_last_rd == c_last_d) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_d = 1'b1;
      end
    end else begin
      w_grant_i = w_i_cand;
      w_grant_d = w_d_read;
    end
  end

  assign i_gnt     = w_grant_i;
  assign d_gnt     = w_d_write | w_grant_d;

  assign ram_wen   = w_d_write;
  assign ram_waddr = d_addr;
  assign ram_wdata = d_wdata;

  assign ram_ren   = w_grant_i | w_grant_d;
  assign ram_raddr = w_grant_d ? d_addr : i_addr;

  // Track the owner of the in-flight read and the round-robin history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= OWN_NONE;
      r_last_rd <= c_last_d;
    end else begin
      if (w_grant_i) begin
        r_owner   <= OWN_I;
        r_last_rd <= c_last_i;
      end else if (w_grant_d) begin
        r_owner   <= OWN_D;
        r_last_rd <= c_last_d;
      end else begin
        r_owner   <= OWN_NONE;
      end
    end
  end

  // Capture each requester's returned word so its rdata stays stable
  // after the valid cycle until its next read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (r_owner == OWN_I) begin
        r_i_hold <= ram_rdata;
      end
      if (r_owner == OWN_D) begin
        r_d_hold <= ram_rdata;
      end
    end
  end

  // Valid flags decode straight from the owner register; the owner sees
  // the live Ram output in its valid cycle, the other sees its held word.
  assign i_rvalid = (r_owner == OWN_I);
  assign d_rvalid = (r_owner == OWN_D);
  assign i_rdata  = i_rvalid ? ram_rdata : r_i_hold;
  assign d_rdata  = d_rvalid ? ram_rdata : r_d_hold;

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter that shares the single-clock dual-port Ram (one write port, one synchronous read port) between the instruction-fetch path (I) and the load/store data path (D) of the rv32i core. It sequences read issue, routes the 1-cycle-latency read data back to the owning requester, and resolves same-address read/write hazards. It sits between the core's fetch/LSU units and the Ram instance.

Parameters:
ADDR_WIDTH, 8, Ram address width (Ram depth = 2**ADDR_WIDTH)
DATA_WIDTH, 32, Ram word width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
i_req  in  1  I read request; held with stable i_addr until i_gnt
i_addr  in  ADDR_WIDTH  I read address
i_gnt  out  1  I request accepted this cycle (combinational)
i_rvalid  out  1  I read data valid (registered)
i_rdata  out  DATA_WIDTH  I read data
d_req  in  1  D request; held with stable d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_WIDTH  D address
d_wdata  in  DATA_WIDTH  D write data
d_gnt  out  1  D request accepted this cycle (combinational)
d_rvalid  out  1  D read data valid (registered; never for writes)
d_rdata  out  DATA_WIDTH  D read data
ram_wen  out  1  Ram write enable
ram_ren  out  1  Ram read enable
ram_waddr  out  ADDR_WIDTH  Ram write address
ram_raddr  out  ADDR_WIDTH  Ram read address
ram_wdata  out  DATA_WIDTH  Ram write data
ram_rdata  in  DATA_WIDTH  Ram read data, valid the cycle after ram_ren issue

Behaviour:
- Reset (rst=0, async): i_rvalid=d_rvalid=0, owner=NONE, last_rd=D (so I wins first tie); i_gnt, d_gnt, ram_wen, ram_ren forced 0 while rst=0; rdata outputs 0.
- D write (d_req & d_we): always granted same cycle; ram_wen=1, ram_waddr=d_addr, ram_wdata=d_wdata. No rvalid.
- Read port: at most one read issued per cycle; ram_ren=1 only in issue cycle, ram_raddr=granted address.
- Read candidates: I if i_req; D if d_req & !d_we.
- Both candidates: round-robin; grant the one not equal to last_rd; last_rd updates to the granted requester on every read grant.
- Single candidate: granted, unless hazard.
- Hazard: I read and D write in the same cycle to the same address -> D write granted, i_gnt=0; I is retried next cycle and returns the newly written data. Different addresses -> both granted same cycle.
- Response: owner register latches the granted read requester; next cycle owner's rvalid=1, its rdata=ram_rdata; the other rvalid=0, its rdata holds its last value. Back-to-back reads give one rvalid per cycle, 1-cycle latency, full throughput.
- Unowned cycles: both rvalid=0, owner=NONE.
- No request queueing: requesters must hold until gnt; dropping req before gnt is legal and cancels with no side effects.
- Async reset mid-operation: an in-flight read is discarded (no rvalid after reset release), last_rd returns to D.
- Address wrap: addresses are used unmodified; no range checks.

Test Plan:
- Reset: rst=0 with i_req=d_req=1 -> all gnt/rvalid/ram_wen/ram_ren=0; rst 0->1 with only i_req, i_addr=3 -> i_gnt=1, ram_raddr=3, next cycle i_rvalid=1.
- Write then read: D write addr=1 data=256, next cycle D read addr=1 -> d_gnt both cycles, one cycle later d_rvalid=1, d_rdata=256, i_rvalid=0.
- Contention: i_req(addr 2) and D read(addr 5) held 4 cycles -> grants I,D,I,D; rvalid alternates i,d,i,d with data of addr 2/5.
- Hazard: preload addr 7=0xAA; same cycle D write addr7=0x55 and I read addr7 -> d_gnt=1, i_gnt=0; next cycle i_gnt=1; then i_rdata=0x55.
- Parallel: D write addr 4=9 and I read addr 6 same cycle -> both gnt=1, ram_wen=ram_ren=1.
- Reset mid-read: I read granted, rst=0 before next edge -> i_rvalid stays 0 after release; next tie grants I first.
